// File: rtl/display_controller.sv
// ============================================================================
// display_controller : binary-to-BCD display controller for eight 7-seg digits
// Shift-and-add-3 conversion, leading-zero blanking, overflow dashes.
// Optional signed mode: define DISPLAY_SIGNED_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_controller #(
  parameter int DATA_W = 32,
  parameter int N_DIG  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    valor,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [4*N_DIG-1:0]   digitos
);

  localparam int BCD_W = 4 * (N_DIG + 2);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef DISPLAY_SIGNED_EN
  localparam int CAP = N_DIG - 1;
`else
  localparam int CAP = N_DIG;
`endif
  localparam logic [3:0] C_DASH  = 4'b1011;
  localparam logic [3:0] C_BLANK = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FORMAT = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_op;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [DATA_W-1:0]   w_operand;
  logic                w_ovf;
  logic                w_seen;
  logic [N_DIG-1:0]    w_show;
  logic [4*N_DIG-1:0]  w_fmt;
`ifdef DISPLAY_SIGNED_EN
  logic                r_neg;
  logic [N_DIG-1:0]    w_show_sh;
`endif

`ifdef DISPLAY_SIGNED_EN
  // Magnitude of the most negative value wraps to itself, which is still the correct unsigned magnitude.
  assign w_operand = valor[DATA_W-1] ? (~valor + 1'b1) : valor;
  assign w_show_sh = {w_show[N_DIG-2:0], 1'b0};
`else
  assign w_operand = valor;
`endif

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < N_DIG + 2; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_ovf = |r_bcd[BCD_W-1:4*CAP];

  always_comb begin
    w_seen = 1'b0;
    w_show = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      if ((i < CAP) && (r_bcd[4*i +: 4] != 4'd0))
        w_seen = 1'b1;
      w_show[i] = w_seen || (i == 0);
    end
  end

  always_comb begin
    w_fmt = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (w_ovf)
        w_fmt[4*i +: 4] = C_DASH;
      else if (w_show[i])
        w_fmt[4*i +: 4] = r_bcd[4*i +: 4];
`ifdef DISPLAY_SIGNED_EN
      // Sign sits directly left of the most significant shown digit.
      else if (r_neg && w_show_sh[i])
        w_fmt[4*i +: 4] = C_DASH;
`endif
      else
        w_fmt[4*i +: 4] = C_BLANK;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_bcd    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digitos  <= {{(N_DIG-1){C_BLANK}}, 4'b0000};
`ifdef DISPLAY_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= w_operand;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
`ifdef DISPLAY_SIGNED_EN
            r_neg   <= valor[DATA_W-1];
`endif
          end
        end
        S_SHIFT: begin
          {r_bcd, r_op} <= {w_bcd_adj, r_op} << 1;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1))
            r_state <= S_FORMAT;
        end
        S_FORMAT: begin
          digitos  <= w_fmt;
          overflow <= w_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_controller.sv
// ============================================================================
// tb_display_controller : randomized + directed self-checking bench for
// display_controller, against an arithmetic decimal-formatting model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] valor = '0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] digitos;

  int checks = 0;
  int errors = 0;

  display_controller #(.DATA_W(32), .N_DIG(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .valor    (valor),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digitos  (digitos)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal rendering of a value as the display should show it.
  function automatic void model(input logic [31:0] v, output logic [31:0] d, output logic o);
    longint mag;
    longint lim;
    bit     neg;
    int     cap;
    int     nd;
    mag = longint'({32'd0, v});
    neg = 1'b0;
`ifdef DISPLAY_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      mag = 64'h1_0000_0000 - mag;
    end
    cap = 7;
`else
    cap = 8;
`endif
    lim = 1;
    for (int k = 0; k < cap; k++) lim = lim * 10;
    if (mag >= lim) begin
      d = 32'hBBBBBBBB;
      o = 1'b1;
      return;
    end
    o  = 1'b0;
    d  = 32'hFFFFFFFF;
    nd = 0;
    do begin
      d[4*nd +: 4] = 4'(mag % 10);
      mag = mag / 10;
      nd++;
    end while (mag != 0);
    if (neg) d[4*nd +: 4] = 4'hB;
  endfunction

  // Waits for done after the accepting edge; returns edges counted (0 = timed out).
  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(posedge clock); #1;
      n++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      errors++;
      $display("FAIL done_timeout observed=no_done expected=done_within_60");
      n = 0;
    end
  endtask

  task automatic run_conv(input logic [31:0] v);
    logic [31:0] ed;
    logic        eo;
    logic [31:0] prev;
    int          n;
    bit          got;
    model(v, ed, eo);
    prev = digitos;
    @(negedge clock);
    valor = v;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    valor = $urandom();
    check("busy_after_accept", 64'(busy), 64'd1);
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(posedge clock); #1;
      n++;
      if (n == 10) begin
        check("digitos_hold", 64'(digitos), 64'(prev));
        check("busy_mid", 64'(busy), 64'd1);
      end
      if (done) got = 1'b1;
    end
    check("latency", 64'(n), 64'd33);
    check("busy_with_done", 64'(busy), 64'd0);
    check("digitos", 64'(digitos), 64'(ed));
    check("overflow", 64'(overflow), 64'(eo));
    @(posedge clock); #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] ed;
    logic        eo;
    logic [31:0] v;
    int          n;
    int          ndone;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_digitos", 64'(digitos), 64'hFFFFFFF0);
    @(negedge clock);
    reset = 1'b1;

    // Reset in the middle of a conversion
    @(negedge clock);
    valor = 32'd1234;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_digitos", 64'(digitos), 64'hFFFFFFF0);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    check("midrst_digitos_after", 64'(digitos), 64'hFFFFFFF0);

    // Directed values
    run_conv(32'd1234);
    run_conv(32'd0);
`ifdef DISPLAY_SIGNED_EN
    run_conv(-32'sd45);
    run_conv(-32'sd10000000);
    run_conv(32'h80000000);
    run_conv(32'd9999999);
    run_conv(-32'sd9999999);
    run_conv(32'd10000000);
    run_conv(32'hFFFFFFFF);
`else
    run_conv(32'd99999999);
    run_conv(32'd100000000);
    run_conv(32'hFFFFFFFF);
    run_conv(32'd10000000);
`endif
    run_conv(32'd7);

    // Start pulses while busy are ignored
    model(32'd777, ed, eo);
    @(negedge clock);
    valor = 32'd777;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock); #1;
      start = (k == 5 || k == 20);
      if (k == 5 || k == 20) valor = 32'd55;
      if (done) ndone++;
    end
    start = 1'b0;
    check("ignored_start_one_done", 64'(ndone), 64'd1);
    check("ignored_start_digitos", 64'(digitos), 64'(ed));

    // Start held across done: next conversion begins immediately
    @(negedge clock);
    valor = 32'd4321;
    start = 1'b1;
    @(posedge clock); #1;
    valor = 32'd86;
    wait_done(n);
    check("held_latency", 64'(n), 64'd33);
    check("held_busy_at_done", 64'(busy), 64'd0);
    model(32'd4321, ed, eo);
    check("held_first_digitos", 64'(digitos), 64'(ed));
    @(posedge clock); #1;
    start = 1'b0;
    check("held_busy_rises", 64'(busy), 64'd1);
    check("held_done_low", 64'(done), 64'd0);
    wait_done(n);
    model(32'd86, ed, eo);
    check("held_second_latency", 64'(n), 64'd33);
    check("held_second_digitos", 64'(digitos), 64'(ed));
    @(posedge clock); #1;

    // Randomized values across magnitude ranges
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom();
        1: v = $urandom_range(0, 99999999);
        2: v = $urandom_range(0, 9999999);
        default: v = $urandom_range(0, 999);
      endcase
`ifdef DISPLAY_SIGNED_EN
      if ($urandom_range(0, 1) == 1) v = -v;
`endif
      run_conv(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
